vert_line_filter: RTL and testbench

Parametrised vertical line filter and deinterlacer for the TV-in to VGA video path. It sits between the SDRAM field readback and the YUV 4:2:2 to 4:4:4 converter, and owns two internal line buffers. It produces bypass, line-repeat, 2-tap average or 3-tap [1 2 1]/4 blended pixels, selectable per line at run time. It generalises the fixed two-line-buffer averaging path with configurable component width, component count and line length.

---
 rtl/vert_line_filter.sv | 166 ++++++++++++++++
 tb/tb_vert_line_filter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vert_line_filter.sv
// vert_line_filter
//   Vertical line filter / deinterlacer between SDRAM field readback and the
//   4:2:2 -> 4:4:4 converter. Keeps the two previous lines in internal RAM
//   and outputs, per line, bypass / line repeat / 2-tap average / [1 2 1]/4.
//   Two-register latency (RAM read + input reg, then arithmetic reg).
//
//   Optional feature: define VLF_ROUND_EN for round-to-nearest averaging;
//   undefined gives the truncating arithmetic of the legacy averaging path.
//
// Ports
//   iCLK        pixel clock
//   iRESET      asynchronous active-high reset
//   iDATA       current pixel, component k at [k*COMP_W +: COMP_W]
//   iDVAL       pixel enable
//   iSOL        start of line (qualified by iDVAL)
//   iMODE       0 bypass, 1 repeat, 2 two-tap, 3 three-tap (latched at SOL)
//   oDATA       filtered pixel
//   oDVAL       iDVAL delayed by two registers
//   oLINES_RDY  two full prior lines are held in the buffers

// Per-component filter arithmetic (combinational).
module vlf_comp #(
  parameter int COMP_W = 8
) (
  input  logic [COMP_W-1:0] a,
  input  logic [COMP_W-1:0] b,
  input  logic [COMP_W-1:0] c,
  input  logic [1:0]        mode,
  output logic [COMP_W-1:0] y
);
  localparam int W2 = COMP_W + 2;
  logic [W2-1:0] ax, bx, cx;
  assign ax = {2'b00, a};
  assign bx = {2'b00, b};
  assign cx = {2'b00, c};

  always_comb begin
    y = c;
    unique case (mode)
      2'd0: y = c;
      2'd1: y = b;
`ifdef VLF_ROUND_EN
      2'd2: y = COMP_W'((bx + cx + W2'(1)) >> 1);
      2'd3: y = COMP_W'((ax + (bx << 1) + cx + W2'(2)) >> 2);
`else
      2'd2: y = COMP_W'((bx + cx) >> 1);
      2'd3: y = COMP_W'(((ax + cx) >> 2) + (bx >> 1));
`endif
    endcase
  end
endmodule

module vert_line_filter #(
  parameter int COMP_W   = 8,
  parameter int NUM_COMP = 2,
  parameter int LINE_LEN = 640,
  parameter int PTR_W    = 10
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic [NUM_COMP*COMP_W-1:0] iDATA,
  input  logic                       iDVAL,
  input  logic                       iSOL,
  input  logic [1:0]                 iMODE,
  output logic [NUM_COMP*COMP_W-1:0] oDATA,
  output logic                       oDVAL,
  output logic                       oLINES_RDY
);
  localparam int DW = NUM_COMP * COMP_W;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(LINE_LEN - 1);

  logic             pix_sol;
  logic [PTR_W-1:0] nxt_col, cur_col;
  logic             over_r, cur_over, wr_en;
  logic [1:0]       cnt, mode_r, mode_cur, mode_eff;
  logic             wr_seen, rdy_cur;

  assign pix_sol  = iDVAL & iSOL;
  assign cur_col  = pix_sol ? '0 : nxt_col;
  assign cur_over = pix_sol ? 1'b0 : over_r;
  assign wr_en    = iDVAL & ~cur_over;
  assign mode_cur = pix_sol ? iMODE : mode_r;
  // The SOL pixel that completes the second line is already filtered.
  assign rdy_cur  = (cnt == 2'd2) | (pix_sol & wr_seen & (cnt == 2'd1));
  assign mode_eff = (rdy_cur & ~cur_over) ? mode_cur : 2'd0;
  assign oLINES_RDY = (cnt == 2'd2);

  // Line buffers: buf0 = line n-1, buf1 = line n-2.
  logic [DW-1:0]    buf0 [LINE_LEN];
  logic [DW-1:0]    buf1 [LINE_LEN];
  logic [DW-1:0]    rd0, rd1;
  logic             mv_en;
  logic [PTR_W-1:0] mv_addr;

  // buf0 -> buf1 move lands one cycle after the read. A pixel reading the
  // column being moved (back-to-back SOLs at column 0) takes the moved value.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      rd0 <= buf0[cur_col];
      rd1 <= (mv_en && mv_addr == cur_col) ? rd0 : buf1[cur_col];
    end
    if (wr_en) buf0[cur_col] <= iDATA;
    if (mv_en) buf1[mv_addr] <= rd0;
  end

  // Pointer, line counter, mode latch.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      nxt_col <= '0;
      over_r  <= 1'b0;
      cnt     <= 2'd0;
      wr_seen <= 1'b0;
      mode_r  <= 2'd0;
      mv_en   <= 1'b0;
      mv_addr <= '0;
    end else begin
      mv_en   <= wr_en;
      mv_addr <= cur_col;
      if (iDVAL) begin
        if (cur_over || cur_col == LAST) begin
          nxt_col <= LAST;
          over_r  <= 1'b1;
        end else begin
          nxt_col <= cur_col + PTR_W'(1);
          over_r  <= 1'b0;
        end
        if (pix_sol) begin
          mode_r <= iMODE;
          if (wr_seen && cnt != 2'd2) cnt <= cnt + 2'd1;
        end
        if (wr_en) wr_seen <= 1'b1;
      end
    end
  end

  // Pipeline.
  logic [2:1]    vld_pipe;
  logic [DW-1:0] s1_c, filt;
  logic [1:0]    s1_mode;

  for (genvar k = 0; k < NUM_COMP; k++) begin : g_comp
    vlf_comp #(.COMP_W(COMP_W)) u_comp (
      .a    (rd1[k*COMP_W +: COMP_W]),
      .b    (rd0[k*COMP_W +: COMP_W]),
      .c    (s1_c[k*COMP_W +: COMP_W]),
      .mode (s1_mode),
      .y    (filt[k*COMP_W +: COMP_W])
    );
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      vld_pipe <= '0;
      s1_c     <= '0;
      s1_mode  <= 2'd0;
      oDATA    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], iDVAL};
      s1_c     <= iDATA;
      s1_mode  <= mode_eff;
      oDATA    <= filt;
    end
  end

  assign oDVAL = vld_pipe[2];
endmodule

// File: tb/tb_vert_line_filter.sv
module tb_vert_line_filter;
  localparam int CW = 8, NC = 2, LL = 640, DW = CW * NC, MAXC = 8192;

  logic          iCLK, iRESET, iDVAL, iSOL, oDVAL, oLINES_RDY;
  logic [DW-1:0] iDATA, oDATA;
  logic [1:0]    iMODE;

  vert_line_filter #(.COMP_W(CW), .NUM_COMP(NC), .LINE_LEN(LL), .PTR_W(10)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iDVAL(iDVAL), .iSOL(iSOL),
    .iMODE(iMODE), .oDATA(oDATA), .oDVAL(oDVAL), .oLINES_RDY(oLINES_RDY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks = 0, errors = 0;

  // Reference model: last two values written at each column, count of
  // completed lines, latched mode, pixel index within the line.
  logic [DW-1:0] h1 [LL];
  logic [DW-1:0] h2 [LL];
  int            nl, idx;
  bit            any_wr;
  logic [1:0]    mmode;

  // Per-cycle records (index = accept edge of the cycle).
  logic [DW-1:0] exp_d [MAXC];
  logic [DW-1:0] obs_d [MAXC];
  logic [DW-1:0] in_d  [MAXC];
  bit            exp_v [MAXC];
  logic          obs_v [MAXC];
  logic          obs_r [MAXC];
  int            cyc;

  function automatic logic [DW-1:0] filt(input logic [1:0] m, input logic [DW-1:0] a, b, c);
    logic [DW-1:0] r;
    int av, bv, cv, y;
    r = '0;
    for (int k = 0; k < NC; k++) begin
      av = int'(a[k*CW +: CW]);
      bv = int'(b[k*CW +: CW]);
      cv = int'(c[k*CW +: CW]);
      y  = cv;
      case (m)
        2'd1: y = bv;
`ifdef VLF_ROUND_EN
        2'd2: y = (bv + cv + 1) / 2;
        2'd3: y = (av + 2 * bv + cv + 2) / 4;
`else
        2'd2: y = (bv + cv) / 2;
        2'd3: y = (av + cv) / 4 + bv / 2;
`endif
        default: y = cv;
      endcase
      r[k*CW +: CW] = CW'(y);
    end
    return r;
  endfunction

  // One clock: present inputs, update model at the edge, record outputs.
  task automatic step(input bit v, input bit s, input logic [DW-1:0] d, input logic [1:0] m);
    iDVAL = v; iSOL = s; iDATA = d; iMODE = m;
    @(posedge iCLK);
    if (cyc >= MAXC) begin
      $display("FAIL record_overflow cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    in_d[cyc]  = d;
    exp_v[cyc] = v;
    exp_d[cyc] = '0;
    if (v) begin
      if (s) begin
        if (any_wr && nl < 2) nl++;
        mmode = m;
        idx = 0;
      end
      if (idx < LL) begin
        exp_d[cyc] = (nl >= 2) ? filt(mmode, h2[idx], h1[idx], d) : d;
        h2[idx] = h1[idx];
        h1[idx] = d;
        any_wr = 1'b1;
      end else begin
        exp_d[cyc] = d;
      end
      idx++;
    end
    @(negedge iCLK);
    obs_d[cyc] = oDATA;
    obs_v[cyc] = oDVAL;
    obs_r[cyc] = oLINES_RDY;
    cyc++;
  endtask

  task automatic send_line(input int n, input logic [1:0] m, input bit rnd, input logic [DW-1:0] val);
    for (int p = 0; p < n; p++) step(1'b1, p == 0, rnd ? DW'($urandom) : val, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 2'd0);
  endtask

  task automatic do_reset;
    iRESET = 1'b1; iDVAL = 1'b0; iSOL = 1'b0; iDATA = '0; iMODE = 2'd0;
    @(negedge iCLK);
    @(negedge iCLK);
    iRESET = 1'b0;
    nl = 0; idx = 0; any_wr = 1'b0; mmode = 2'd0; cyc = 0;
  endtask

  task automatic test_reset;
    int cut;
    do_reset();
    checks++;
    if (oDATA !== '0 || oDVAL !== 1'b0 || oLINES_RDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got data=%h dval=%b rdy=%b want 0/0/0", oDATA, oDVAL, oLINES_RDY);
    end
    send_line(LL, 2'd3, 1'b1, '0);
    send_line(LL, 2'd3, 1'b1, '0);
    for (int p = 0; p < 300; p++) step(1'b1, p == 0, DW'($urandom), 2'd3);
    cut = cyc;
    for (int k = 0; k + 1 < cut; k++) begin
      checks++;
      if (obs_v[k+1] !== exp_v[k] || (exp_v[k] && obs_d[k+1] !== exp_d[k])) begin
        errors++;
        $display("FAIL reset_preline k=%0d got %b/%h want %b/%h", k, obs_v[k+1], obs_d[k+1], exp_v[k], exp_d[k]);
      end
    end
    // Pixel 300 is on the bus when reset hits.
    iDVAL = 1'b1; iSOL = 1'b0; iDATA = DW'($urandom);
    #2 iRESET = 1'b1;
    #1;
    checks++;
    if (oDATA !== '0 || oDVAL !== 1'b0 || oLINES_RDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got data=%h dval=%b rdy=%b want 0/0/0", oDATA, oDVAL, oLINES_RDY);
    end
    @(negedge iCLK);
    iDVAL = 1'b0;
    @(negedge iCLK);
    iRESET = 1'b0;
    nl = 0; idx = 0; any_wr = 1'b0; mmode = 2'd0; cyc = 0;
    send_line(LL, 2'd3, 1'b1, '0);
    send_line(LL, 2'd3, 1'b1, '0);
    send_line(LL, 2'd3, 1'b1, '0);
    idle(3);
    for (int k = 0; k + 1 < cyc; k++) begin
      checks++;
      if (obs_v[k+1] !== exp_v[k] || (exp_v[k] && obs_d[k+1] !== exp_d[k])) begin
        errors++;
        $display("FAIL reset_after k=%0d got %b/%h want %b/%h", k, obs_v[k+1], obs_d[k+1], exp_v[k], exp_d[k]);
      end
    end
    // First two lines after release must be plain passthrough.
    for (int k = 0; k < 2 * LL; k += 97) begin
      checks++;
      if (obs_d[k+1] !== in_d[k]) begin
        errors++;
        $display("FAIL reset_hides_stale k=%0d got %h want %h", k, obs_d[k+1], in_d[k]);
      end
    end
  endtask

  task automatic test_bypass;
    do_reset();
    for (int p = 0; p < 40; p++) step(1'b1, p == 0, DW'(p), 2'd0);
    idle(5);
    for (int p = 40; p < 80; p++) step(1'b1, 1'b0, DW'(p), 2'd0);
    idle(3);
    for (int k = 0; k + 1 < cyc; k++) begin
      checks++;
      if (obs_v[k+1] !== exp_v[k]) begin
        errors++;
        $display("FAIL bypass_dval k=%0d got %b want %b", k, obs_v[k+1], exp_v[k]);
      end
      if (exp_v[k]) begin
        checks++;
        if (obs_d[k+1] !== in_d[k]) begin
          errors++;
          $display("FAIL bypass_data k=%0d got %h want %h", k, obs_d[k+1], in_d[k]);
        end
      end
    end
  endtask

  task automatic test_line_repeat;
    int s3;
    do_reset();
    send_line(LL, 2'd1, 1'b0, 16'h1010);
    send_line(LL, 2'd1, 1'b0, 16'h2020);
    s3 = cyc;
    send_line(LL, 2'd1, 1'b0, 16'h3030);
    idle(3);
    checks++;
    if (obs_r[s3-1] !== 1'b0 || obs_r[s3] !== 1'b1) begin
      errors++;
      $display("FAIL repeat_rdy_edge got %b->%b want 0->1", obs_r[s3-1], obs_r[s3]);
    end
    for (int p = 0; p < LL; p++) begin
      checks++;
      if (obs_d[s3+p+1] !== 16'h2020) begin
        errors++;
        $display("FAIL repeat_line3 p=%0d got %h want 2020", p, obs_d[s3+p+1]);
      end
    end
    for (int p = 0; p < LL; p += 64) begin
      checks++;
      if (obs_d[LL+p+1] !== 16'h2020) begin
        errors++;
        $display("FAIL repeat_line2_pass p=%0d got %h want 2020", p, obs_d[LL+p+1]);
      end
    end
  endtask

  task automatic test_blend;
    int s3;
    logic [DW-1:0] want;
`ifdef VLF_ROUND_EN
    want = 16'h8080;
`else
    want = 16'h7F7F;
`endif
    do_reset();
    send_line(LL, 2'd3, 1'b0, 16'hFFFF);
    send_line(LL, 2'd3, 1'b0, 16'h0101);
    s3 = cyc;
    send_line(LL, 2'd3, 1'b0, 16'hFEFE);
    idle(3);
    for (int p = 0; p < LL; p++) begin
      checks++;
      if (obs_d[s3+p+1] !== want) begin
        errors++;
        $display("FAIL blend p=%0d got %h want %h", p, obs_d[s3+p+1], want);
      end
    end
  endtask

  task automatic test_mode_latch;
    int s3, s4;
    do_reset();
    send_line(LL, 2'd3, 1'b1, '0);
    send_line(LL, 2'd3, 1'b1, '0);
    s3 = cyc;
    for (int p = 0; p < LL; p++) step(1'b1, p == 0, DW'($urandom), (p < 100) ? 2'd3 : 2'd0);
    s4 = cyc;
    send_line(LL, 2'd0, 1'b1, '0);
    idle(3);
    for (int k = s3; k + 1 < cyc; k++) begin
      checks++;
      if (obs_v[k+1] !== exp_v[k] || (exp_v[k] && obs_d[k+1] !== exp_d[k])) begin
        errors++;
        $display("FAIL mode_latch k=%0d got %b/%h want %b/%h", k, obs_v[k+1], obs_d[k+1], exp_v[k], exp_d[k]);
      end
    end
    for (int p = 0; p < LL; p += 50) begin
      checks++;
      if (obs_d[s4+p+1] !== in_d[s4+p]) begin
        errors++;
        $display("FAIL mode_latch_bypass p=%0d got %h want %h", p, obs_d[s4+p+1], in_d[s4+p]);
      end
    end
  endtask

  task automatic test_overlong;
    int s2, s3;
    do_reset();
    send_line(700, 2'd1, 1'b1, '0);
    s2 = cyc;
    send_line(700, 2'd1, 1'b1, '0);
    s3 = cyc;
    send_line(700, 2'd1, 1'b1, '0);
    idle(3);
    checks++;
    if (obs_d[s3+639+1] !== in_d[s2+639]) begin
      errors++;
      $display("FAIL overlong_b639 got %h want %h", obs_d[s3+639+1], in_d[s2+639]);
    end
    for (int p = 640; p < 700; p++) begin
      checks++;
      if (obs_d[s3+p+1] !== in_d[s3+p]) begin
        errors++;
        $display("FAIL overlong_tail p=%0d got %h want %h", p, obs_d[s3+p+1], in_d[s3+p]);
      end
    end
    for (int k = 0; k + 1 < cyc; k++) begin
      checks++;
      if (obs_v[k+1] !== exp_v[k] || (exp_v[k] && obs_d[k+1] !== exp_d[k])) begin
        errors++;
        $display("FAIL overlong k=%0d got %b/%h want %b/%h", k, obs_v[k+1], obs_d[k+1], exp_v[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_random;
    int n;
    bit v;
    do_reset();
    for (int l = 0; l < 10; l++) begin
      n = $urandom_range(48, 16);
      step(1'b1, 1'b1, DW'($urandom), 2'($urandom));
      for (int p = 1; p < n; p++) begin
        v = ($urandom_range(3, 0) != 0);
        if (v) p = p; else p--;
        step(v, v ? 1'b0 : 1'($urandom), DW'($urandom), 2'($urandom));
      end
    end
    idle(3);
    for (int k = 0; k + 1 < cyc; k++) begin
      checks++;
      if (obs_v[k+1] !== exp_v[k] || (exp_v[k] && obs_d[k+1] !== exp_d[k])) begin
        errors++;
        $display("FAIL random k=%0d got %b/%h want %b/%h", k, obs_v[k+1], obs_d[k+1], exp_v[k], exp_d[k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < LL; i++) begin
      h1[i] = '0;
      h2[i] = '0;
    end
    iRESET = 1'b1; iDVAL = 1'b0; iSOL = 1'b0; iDATA = '0; iMODE = 2'd0;
    nl = 0; idx = 0; any_wr = 1'b0; mmode = 2'd0; cyc = 0;
    test_reset();
    test_bypass();
    test_line_repeat();
    test_blend();
    test_mode_latch();
    test_overlong();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
